// File: rtl/dcache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W        = 32;
  localparam int WORD_W        = 32;
  localparam int LINE_BITS     = 256;
  localparam int OFF_W         = 5;
  localparam int WSEL_W        = 3;
  localparam int DEF_NUM_LINES = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read, synchronous full-line or single-word write.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter  int NUM_LINES = DEF_NUM_LINES,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = ADDR_W - OFF_W - IDX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic                 line_we,
  input  logic [TAG_W-1:0]     line_tag,
  input  logic [LINE_BITS-1:0] line_data,
  input  logic                 word_we,
  input  logic [WSEL_W-1:0]    word_sel,
  input  logic [WORD_W-1:0]    word_data,
  input  logic                 clr_dirty
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_BITS-1:0] data_mem [NUM_LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

  // Only the status bits are reset; tag and data are qualified by valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end else if (clr_dirty) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we) begin
      data_mem[idx] <= line_data;
      tag_mem[idx]  <= line_tag;
    end else if (word_we) begin
      data_mem[idx][word_sel*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage direct-mapped, write-back, write-allocate data cache with line
// writeback/refill over a req/ack memory port and a pipeline stall output.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter  int NUM_LINES = DEF_NUM_LINES,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = ADDR_W - OFF_W - IDX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [WORD_W-1:0]    cpu_wdata_i,
  output logic [WORD_W-1:0]    cpu_rdata_o,
  output logic                 stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  // Memory handshake: mem_enable_o with mem_write_o/mem_addr_o/mem_data_o is
  // held stable until the single-cycle mem_ack_i pulse; ack outside a
  // request is ignored.

  state_t               state;
  state_t               next_state;
  logic [IDX_W-1:0]     req_idx;
  logic [IDX_W-1:0]     lat_idx;
  logic [IDX_W-1:0]     arr_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [TAG_W-1:0]     lat_tag;
  logic [TAG_W-1:0]     rd_tag;
  logic [WSEL_W-1:0]    req_word;
  logic [LINE_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_dirty;
  logic                 hit;
  logic                 miss;
  logic                 line_we;
  logic                 word_we;
  logic                 clr_dirty;
  logic                 latch_req;
  logic [1:0]           unused_addr;

  assign req_word    = cpu_addr_i[OFF_W-1:2];
  assign req_idx     = cpu_addr_i[OFF_W +: IDX_W];
  assign req_tag     = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign unused_addr = cpu_addr_i[1:0];

  // While a miss is in flight the array is addressed by the latched index.
  assign arr_idx = (state == ST_IDLE) ? req_idx : lat_idx;
  assign hit     = cpu_req_i & rd_valid & (rd_tag == req_tag);
  assign miss    = cpu_req_i & ~hit;

  // Gated by reset so the pipeline is released while the cache is held in reset.
  assign stall_o = rst_i & ((state != ST_IDLE) | miss);

  dcache_sram #(
    .NUM_LINES (NUM_LINES)
  ) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx       (arr_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .line_we   (line_we),
    .line_tag  (lat_tag),
    .line_data (mem_data_i),
    .word_we   (word_we),
    .word_sel  (req_word),
    .word_data (cpu_wdata_i),
    .clr_dirty (clr_dirty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lat_idx <= '0;
      lat_tag <= '0;
    end else if (latch_req) begin
      lat_idx <= req_idx;
      lat_tag <= req_tag;
    end
  end

  always_comb begin
    next_state   = state;
    line_we      = 1'b0;
    word_we      = 1'b0;
    clr_dirty    = 1'b0;
    latch_req    = 1'b0;
    cpu_rdata_o  = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          cpu_rdata_o = rd_data[req_word*WORD_W +: WORD_W];
          word_we     = cpu_write_i;
        end else if (cpu_req_i) begin
          latch_req  = 1'b1;
          next_state = (rd_valid & rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, lat_idx, {OFF_W{1'b0}}};
        mem_data_o   = rd_data;
        if (mem_ack_i) begin
          clr_dirty  = 1'b1;
          next_state = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {lat_tag, lat_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          line_we    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: misses, hits, eviction, idle behaviour and
// reset during a refill, with the memory side served from bench tasks.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_write_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_wdata_i = '0;
  logic [31:0]  cpu_rdata_o;
  logic         stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;
  int en_cnt = 0;
  logic [31:0]  exp_q[$];
  logic [255:0] line_a, line_a_mod, line_b, line_c, line_c_mod, line_d, line_e, line_f;

  dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_write_i  (cpu_write_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .stall_o      (stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  // Clock / reset block
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (stall_o) stall_cnt++;
    if (mem_enable_o) en_cnt++;
  end

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic req, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    cpu_req_i   = req;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
  endtask

  // Called in the first cycle the request should be on the bus; acks after lat cycles.
  task automatic mem_txn(input string name, input logic exp_wr, input logic [31:0] exp_addr,
                         input logic [255:0] exp_line, input logic [255:0] fill, input int lat);
    #1;
    checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== exp_wr || mem_addr_o !== exp_addr) begin
      errors++;
      $display("FAIL %s_req: en=%b wr=%b addr=%h, expected en=1 wr=%b addr=%h",
               name, mem_enable_o, mem_write_o, mem_addr_o, exp_wr, exp_addr);
    end
    if (exp_wr) begin
      checks++;
      if (mem_data_o !== exp_line) begin
        errors++;
        $display("FAIL %s_wdata: got %h expected %h", name, mem_data_o, exp_line);
      end
    end
    repeat (lat) tick();
    checks++;
    if (mem_enable_o !== 1'b1 || mem_addr_o !== exp_addr) begin
      errors++;
      $display("FAIL %s_hold: en=%b addr=%h, expected en=1 addr=%h",
               name, mem_enable_o, mem_addr_o, exp_addr);
    end
    mem_ack_i  = 1'b1;
    mem_data_i = exp_wr ? '0 : fill;
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    drive_req(1'b0, 1'b0, '0, '0);
    rst_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (stall_o !== 1'b0 || mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 ||
        mem_addr_o !== '0 || mem_data_o !== '0 || cpu_rdata_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b en=%b wr=%b addr=%h rdata=%h, expected all zero",
               stall_o, mem_enable_o, mem_write_o, mem_addr_o, cpu_rdata_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if (stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: stall=%b en=%b, expected 0 0", stall_o, mem_enable_o);
    end
  endtask

  task automatic test_cold_load();
    tick();
    stall_cnt = 0;
    en_cnt = 0;
    drive_req(1'b1, 1'b0, 32'h0000_0404, '0);
    #1;
    checks++;
    if (stall_o !== 1'b1 || mem_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL cold_miss_detect: stall=%b en=%b, expected 1 0", stall_o, mem_enable_o);
    end
    tick();
    mem_txn("cold_fetch", 1'b0, 32'h0000_0400, '0, line_a, 10);
    #1;
    checks++;
    if (stall_o !== 1'b0 || cpu_rdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cold_hit: stall=%b rdata=%h, expected 0 deadbeef", stall_o, cpu_rdata_o);
    end
    checks++;
    if (stall_cnt != 12 || en_cnt != 11) begin
      errors++;
      $display("FAIL cold_cycles: stall_cycles=%0d en_cycles=%0d, expected 12 11", stall_cnt, en_cnt);
    end
  endtask

  task automatic test_store_hit();
    tick();
    en_cnt = 0;
    drive_req(1'b1, 1'b1, 32'h0000_0404, 32'h1234_5678);
    #1;
    checks++;
    if (stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL store_hit: stall=%b en=%b, expected 0 0", stall_o, mem_enable_o);
    end
    tick();
    drive_req(1'b1, 1'b0, 32'h0000_0404, '0);
    #1;
    checks++;
    if (stall_o !== 1'b0 || cpu_rdata_o !== 32'h1234_5678 || en_cnt != 0) begin
      errors++;
      $display("FAIL store_readback: stall=%b rdata=%h en_cycles=%0d, expected 0 12345678 0",
               stall_o, cpu_rdata_o, en_cnt);
    end
  endtask

  task automatic test_evict();
    tick();
    drive_req(1'b1, 1'b0, 32'h0000_0804, '0);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL evict_miss: stall=%b, expected 1", stall_o);
    end
    tick();
    mem_txn("evict_wb", 1'b1, 32'h0000_0400, line_a_mod, '0, 3);
    mem_txn("evict_fetch", 1'b0, 32'h0000_0800, '0, line_b, 4);
    #1;
    checks++;
    if (stall_o !== 1'b0 || cpu_rdata_o !== 32'hB000_0001) begin
      errors++;
      $display("FAIL evict_hit: stall=%b rdata=%h, expected 0 b0000001", stall_o, cpu_rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 8; w++) exp_q.push_back(32'hB000_0000 + 32'(w));
    tick();
    stall_cnt = 0;
    for (int w = 0; w < 8; w++) begin
      logic [31:0] exp;
      drive_req(1'b1, 1'b0, 32'h0000_0800 + 32'(w * 4), '0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata_o !== exp || stall_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b_word%0d: rdata=%h stall=%b, expected %h 0", w, cpu_rdata_o, stall_o, exp);
      end
      tick();
    end
    checks++;
    if (stall_cnt != 0) begin
      errors++;
      $display("FAIL b2b_stall_cycles: got %0d expected 0", stall_cnt);
    end
  endtask

  task automatic test_store_miss();
    drive_req(1'b1, 1'b1, 32'h0000_0028, 32'hCAFE_F00D);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL smiss_detect: stall=%b, expected 1", stall_o);
    end
    tick();
    mem_txn("smiss_fetch", 1'b0, 32'h0000_0020, '0, line_c, 2);
    #1;
    checks++;
    if (stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL smiss_merge: stall=%b en=%b, expected 0 0", stall_o, mem_enable_o);
    end
    tick();
    drive_req(1'b1, 1'b0, 32'h0000_0028, '0);
    #1;
    checks++;
    if (cpu_rdata_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL smiss_readback: got %h expected cafef00d", cpu_rdata_o);
    end
    tick();
    drive_req(1'b1, 1'b0, 32'h0000_2024, '0);
    tick();
    mem_txn("smiss_wb", 1'b1, 32'h0000_0020, line_c_mod, '0, 1);
    mem_txn("smiss_refetch", 1'b0, 32'h0000_2020, '0, line_d, 1);
    #1;
    checks++;
    if (stall_o !== 1'b0 || cpu_rdata_o !== 32'hD000_0001) begin
      errors++;
      $display("FAIL smiss_hit: stall=%b rdata=%h, expected 0 d0000001", stall_o, cpu_rdata_o);
    end
  endtask

  task automatic test_idle();
    int bad_stall = 0;
    int bad_en = 0;
    int bad_rdata = 0;
    tick();
    drive_req(1'b0, 1'b0, 32'h0000_0804, '0);
    for (int c = 0; c < 20; c++) begin
      mem_ack_i  = 1'($urandom_range(0, 1));
      mem_data_i = {8{$urandom}};
      #1;
      if (stall_o !== 1'b0) bad_stall++;
      if (mem_enable_o !== 1'b0) bad_en++;
      if (cpu_rdata_o !== '0) bad_rdata++;
      tick();
    end
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    checks++;
    if (bad_stall != 0 || bad_en != 0 || bad_rdata != 0) begin
      errors++;
      $display("FAIL idle_quiet: bad stall/en/rdata cycles=%0d/%0d/%0d, expected 0/0/0",
               bad_stall, bad_en, bad_rdata);
    end
    drive_req(1'b1, 1'b0, 32'h0000_0804, '0);
    #1;
    checks++;
    if (stall_o !== 1'b0 || cpu_rdata_o !== 32'hB000_0001) begin
      errors++;
      $display("FAIL idle_acks_ignored: stall=%b rdata=%h, expected 0 b0000001", stall_o, cpu_rdata_o);
    end
  endtask

  task automatic test_reset_mid_alloc();
    tick();
    drive_req(1'b1, 1'b0, 32'h0000_0C00, '0);
    tick();
    #1;
    checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h0000_0C00) begin
      errors++;
      $display("FAIL rstmid_alloc: en=%b wr=%b addr=%h, expected 1 0 00000c00",
               mem_enable_o, mem_write_o, mem_addr_o);
    end
    tick();
    rst_i      = 1'b0;
    mem_ack_i  = 1'b1;
    mem_data_i = line_e;
    #1;
    checks++;
    if (mem_enable_o !== 1'b0 || stall_o !== 1'b0 || mem_addr_o !== '0) begin
      errors++;
      $display("FAIL rstmid_async: en=%b stall=%b addr=%h, expected 0 0 00000000",
               mem_enable_o, stall_o, mem_addr_o);
    end
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    rst_i      = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b1 || mem_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_remiss: stall=%b en=%b, expected 1 0", stall_o, mem_enable_o);
    end
    tick();
    mem_txn("rstmid_fetch", 1'b0, 32'h0000_0C00, '0, line_e, 2);
    #1;
    checks++;
    if (stall_o !== 1'b0 || cpu_rdata_o !== 32'hE000_0000) begin
      errors++;
      $display("FAIL rstmid_hit: stall=%b rdata=%h, expected 0 e0000000", stall_o, cpu_rdata_o);
    end
    tick();
    drive_req(1'b1, 1'b0, 32'h0000_2024, '0);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_invalidated: stall=%b, expected 1", stall_o);
    end
    tick();
    mem_txn("rstmid_fetch2", 1'b0, 32'h0000_2020, '0, line_f, 1);
    #1;
    checks++;
    if (stall_o !== 1'b0 || cpu_rdata_o !== 32'hF000_0001) begin
      errors++;
      $display("FAIL rstmid_hit2: stall=%b rdata=%h, expected 0 f0000001", stall_o, cpu_rdata_o);
    end
  endtask

  initial begin
    line_a            = make_line(32'hA000_0000);
    line_a[63:32]     = 32'hDEAD_BEEF;
    line_a_mod        = line_a;
    line_a_mod[63:32] = 32'h1234_5678;
    line_b            = make_line(32'hB000_0000);
    line_c            = make_line(32'hC000_0000);
    line_c_mod        = line_c;
    line_c_mod[95:64] = 32'hCAFE_F00D;
    line_d            = make_line(32'hD000_0000);
    line_e            = make_line(32'hE000_0000);
    line_f            = make_line(32'hF000_0000);

    test_reset();
    test_cold_load();
    test_store_hit();
    test_evict();
    test_back_to_back();
    test_store_miss();
    test_idle();
    test_reset_mid_alloc();

    tick();
    drive_req(1'b0, 1'b0, '0, '0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
